jtopl_noise_gen: RTL
====================

# jtopl_noise_gen

Parametrised noise source for the JTOPL sound core and future PSG-style cores. It replaces the fixed 23-bit noise register with an LFSR of configurable width and tap. It adds a programmable shift-rate divider, a short-period mode, synchronous seed loading and a shift-strobe output. It sits beside the phase generator; the rhythm section and operators consume `noise`, and test and debug logic reads `lfsr`.

## Interface
- `W`, 23: LFSR width in bits, minimum 8.
- `TAP`, 14: long-mode feedback tap index, 1..W-1.
- `SW`, 7: short-mode segment width, 2..W-1.
- `DW`, 4: divider width.
- `SEED`, `1<<(W-1)`: reset value of the LFSR.

Ports:
- `rst`  in  1: reset, asynchronous, active-high.
- `clk`  in  1: clock.
- `cen`  in  1: clock enable; tie to 1 if unused.
- `div`  in  DW: shift period is div+1 enabled cycles.
- `short`  in  1: 0 = long mode (W bits), 1 = short mode (SW bits).
- `ld`  in  1: synchronous seed load strobe.
- `seed`  in  W: value loaded on `ld`.
- `noise`  out  1: equal to `lfsr[0]`.
- `lfsr`  out  W: full register state.
- `upd`  out  1: one-clk pulse marking a shift.

## Operation
- State:
  - `no[W-1:0]`: the LFSR; `lfsr` drives it directly.
  - `cnt[DW-1:0]`: the divider counter.
  - `upd`: a register.
- Divider: on each `clk` with `cen`=1:
  - If `cnt >= div`: the LFSR shifts and `cnt <= 0`.
  - Otherwise `cnt <= cnt+1`.
  - The `>=` compare guarantees a shift within one period when `div` is lowered mid-count, with no wrap-around through 2^DW.
- Long mode (`short`=0):
  - `nbit = no[0]^no[TAP]`, OR-ed with (`no`==0).
  - `no <= {nbit, no[W-1:1]}`.
- Short mode (`short`=1):
  - `sbit = no[0]^no[1]`, OR-ed with (`no[SW-1:0]`==0).
  - `no[SW-1:0] <= {sbit, no[SW-1:1]}`.
  - `no[W-1:SW]` holds.
  - Period is 127 for SW=7, from the primitive polynomial x^7+x+1.
- Zero guard: an all-zero active segment injects a 1 on its next shift, so the generator never locks.
- Load: `ld`=1 on a `clk` edge sets `no <= seed` and `cnt <= 0`, whatever `cen` is.
  - Load has priority over a coincident shift.
  - `upd` is not asserted for a load.
  - `seed`=0 is accepted; the zero guard recovers on the following shift.
- Mode change: `short` is sampled at each shift only. Toggling it does not clear `no` or `cnt`. On leaving short mode, the held upper bits are reused as they stand.
- `upd` = 1 for exactly the `clk` cycle after each shift edge, else 0.

## Timing
- Reset values: `no` = SEED, `cnt` = 0, `upd` = 0, `noise` = SEED[0].
- Hold `rst` for at least 1 clk. The release edge is synchronous to `clk` at the integration level.
- Shift cadence: with `cen` held at 1 and `div`=d, shifts occur every d+1 clk cycles. The first shift is on the (d+1)-th enabled edge after reset or load.
- Latency: `noise` and `lfsr` change on the shift edge itself, so they are registered outputs. `upd` is aligned with the new `lfsr` value.
- `cen`=0 freezes `cnt`, `no` and the shift schedule. `upd` still drops after its one cycle.
- Reset asserted mid-count: every state returns to its reset value immediately (asynchronous).

## Structure
- A shared `jtopl_pkg` holds the defaults `JTOPL_NOISE_W`=23, `JTOPL_NOISE_TAP`=14 and `JTOPL_NOISE_SW`=7, so the OPL top and the OPLL variants instantiate identically.
- One sub-module, `jtopl_noise_div`, holds `cnt` and the `>=` compare and emits the shift-enable. The LFSR and load logic stay in the parent.

## Test plan
- Reset with defaults → `lfsr`=0x400000, `noise`=0, `upd`=0. With `div`=0 and `cen`=1, the first edge gives `lfsr`=0x200000 and `upd`=1 on the next cycle.
- `short`=1, `ld` with seed=0x000001, `div`=0 → `lfsr[6:0]` returns to 0x01 after exactly 127 shifts and not before. `lfsr[22:7]` stays at 0.
- `div`=3 with `cen` toggling 1,0,1,0… → shifts every 8 clk cycles, and `upd` pulses once per shift.
- While `cnt`=9 with `div`=12, change `div` to 4 → a shift occurs on the next enabled edge and `cnt`=0.
- `ld`=1 with seed=0 on a shift edge → `lfsr`=0 and no `upd`. The next shift gives `lfsr`=0x400000 (zero-guard injection).
- Assert `rst` mid-period with `cnt`=5 → all outputs return to their reset values in the same cycle. After release, the first shift comes after div+1 enabled edges.

Source files
------------

// File: rtl/jtopl_pkg.sv
// Shared JTOPL constants: default noise LFSR geometry used by the OPL and OPLL tops.
package jtopl_pkg;

    localparam int JTOPL_NOISE_W   = 23;
    localparam int JTOPL_NOISE_TAP = 14;
    localparam int JTOPL_NOISE_SW  = 7;
    localparam int JTOPL_NOISE_DW  = 4;

    typedef enum logic {
        NOISE_LONG  = 1'b0,
        NOISE_SHORT = 1'b1
    } noise_mode_e;

endpackage

// File: rtl/jtopl_noise_div.sv
// Shift-rate divider for the noise LFSR: counts enabled cycles and flags the shift edge.
module jtopl_noise_div #(
    parameter int DW = 4
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          ld,
    input  logic [DW-1:0] div,
    output logic          sh
);

    logic [DW-1:0] cnt;
    logic          at_end;

    // >= rather than == so lowering div mid-count never wraps through 2^DW
    assign at_end = cnt >= div;
    assign sh     = cen & ~ld & at_end;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (ld)
            cnt <= '0;
        else if (cen)
            cnt <= at_end ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/jtopl_noise_gen.sv
// Parametrised noise LFSR with long/short modes, programmable shift rate and seed load.
module jtopl_noise_gen
    import jtopl_pkg::*;
#(
    parameter int             W    = JTOPL_NOISE_W,
    parameter int             TAP  = JTOPL_NOISE_TAP,
    parameter int             SW   = JTOPL_NOISE_SW,
    parameter int             DW   = JTOPL_NOISE_DW,
    parameter logic [W-1:0]   SEED = {1'b1, {(W-1){1'b0}}}
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic [DW-1:0] div,
    input  logic          short,
    input  logic          ld,
    input  logic [W-1:0]  seed,
    output logic          noise,
    output logic [W-1:0]  lfsr,
    output logic          upd
);

    logic [W-1:0] no;
    logic [W-1:0] nxt;
    logic         sh;
    logic         nbit;
    logic         sbit;
    noise_mode_e  mode;

    jtopl_noise_div #(.DW(DW)) u_div (
        .rst (rst),
        .clk (clk),
        .cen (cen),
        .ld  (ld),
        .div (div),
        .sh  (sh)
    );

    // Zero guard: an all-zero active segment feeds a 1 so the generator cannot lock up
    assign nbit = (no[0] ^ no[TAP]) | ~|no;
    assign sbit = (no[0] ^ no[1])   | ~|no[SW-1:0];
    assign mode = noise_mode_e'(short);

    // NOTE: default assignment first so no path through the case leaves nxt unassigned (no latch).
    always_comb begin
        nxt = no;
        case (mode)
            NOISE_LONG:  nxt = {nbit, no[W-1:1]};
            NOISE_SHORT: nxt = {no[W-1:SW], sbit, no[SW-1:1]};
            default:     nxt = no;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            no  <= SEED;
            upd <= 1'b0;
        end else begin
            upd <= sh;
            if (ld)
                no <= seed;
            else if (sh)
                no <= nxt;
        end
    end

    assign lfsr  = no;
    assign noise = no[0];

endmodule
